// File: rtl/wheel_pkg.sv
// Shared types and sizes for the wheel state collector and its frame buffer.
package wheel_pkg;
  localparam int NUM_NODES     = 4;
  localparam int POSITION_SIZE = 8;
  localparam int VELOCITY_SIZE = 6;
  localparam int IDX_W         = $clog2(NUM_NODES);
  localparam int CNT_W         = $clog2(NUM_NODES + 1);

  typedef logic signed [POSITION_SIZE-1:0] pos_t;
  typedef logic signed [VELOCITY_SIZE-1:0] vel_t;
  typedef logic [IDX_W-1:0]                node_idx_t;
  typedef logic [CNT_W-1:0]                cnt_t;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_BUSY   = 2'd1,
    ST_COMMIT = 2'd2
  } state_t;

  localparam cnt_t FULL_CNT = cnt_t'(NUM_NODES);

  // A frame is committable only if every node delivered exactly one position and one velocity.
  function automatic logic frame_complete(input cnt_t node_cnt, input cnt_t vel_cnt, input logic bad);
    return (node_cnt == FULL_CNT) && (vel_cnt == FULL_CNT) && !bad;
  endfunction
endpackage

// File: rtl/wheel_state_collector_if.sv
// Streaming link between update_wheel (master) and the state collector (slave).
interface wheel_state_collector_if;
  import wheel_pkg::*;

  // Valid-only strobes, no ready: the collector accepts every strobe in the cycle it is
  // asserted; begin_out is a one-cycle pulse back to the producer.
  pos_t node_in_x;
  pos_t node_in_y;
  logic node_in_valid;
  vel_t vel_in_x;
  vel_t vel_in_y;
  logic vel_in_valid;
  logic result_in;
  logic begin_out;

  modport master (
    output node_in_x, node_in_y, node_in_valid,
    output vel_in_x, vel_in_y, vel_in_valid,
    output result_in,
    input  begin_out
  );

  modport slave (
    input  node_in_x, node_in_y, node_in_valid,
    input  vel_in_x, vel_in_y, vel_in_valid,
    input  result_in,
    output begin_out
  );
endinterface

// File: rtl/wheel_frame_buffer.sv
// Shadow store for one incoming wheel frame: per-stream counters and a sticky overflow flag.
module wheel_frame_buffer
  import wheel_pkg::*;
(
  input  logic                         clk_in,
  input  logic                         rst_in,
  input  logic                         clear_in,
  input  logic                         node_we_in,
  input  pos_t                         node_x_in,
  input  pos_t                         node_y_in,
  input  logic                         vel_we_in,
  input  vel_t                         vel_x_in,
  input  vel_t                         vel_y_in,
  output pos_t [1:0][NUM_NODES-1:0]    shadow_nodes_out,
  output vel_t [1:0][NUM_NODES-1:0]    shadow_vels_out,
  output logic                         frame_ok_out
);
  pos_t [1:0][NUM_NODES-1:0] shadow_nodes_q, shadow_nodes_d;
  vel_t [1:0][NUM_NODES-1:0] shadow_vels_q, shadow_vels_d;
  cnt_t node_cnt_q, node_cnt_d;
  cnt_t vel_cnt_q, vel_cnt_d;
  logic bad_q, bad_d;

  always_comb begin
    shadow_nodes_d = shadow_nodes_q;
    shadow_vels_d  = shadow_vels_q;
    node_cnt_d     = node_cnt_q;
    vel_cnt_d      = vel_cnt_q;
    bad_d          = bad_q;
    if (clear_in) begin
      node_cnt_d = '0;
      vel_cnt_d  = '0;
      bad_d      = 1'b0;
    end
    // Extra strobes beyond a full frame are dropped and poison the frame; counts saturate.
    if (node_we_in) begin
      if (node_cnt_q == FULL_CNT) begin
        bad_d = 1'b1;
      end else begin
        shadow_nodes_d[0][node_idx_t'(node_cnt_q)] = node_x_in;
        shadow_nodes_d[1][node_idx_t'(node_cnt_q)] = node_y_in;
        node_cnt_d = node_cnt_q + cnt_t'(1);
      end
    end
    if (vel_we_in) begin
      if (vel_cnt_q == FULL_CNT) begin
        bad_d = 1'b1;
      end else begin
        shadow_vels_d[0][node_idx_t'(vel_cnt_q)] = vel_x_in;
        shadow_vels_d[1][node_idx_t'(vel_cnt_q)] = vel_y_in;
        vel_cnt_d = vel_cnt_q + cnt_t'(1);
      end
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      shadow_nodes_q <= '0;
      shadow_vels_q  <= '0;
      node_cnt_q     <= '0;
      vel_cnt_q      <= '0;
      bad_q          <= 1'b0;
    end else begin
      shadow_nodes_q <= shadow_nodes_d;
      shadow_vels_q  <= shadow_vels_d;
      node_cnt_q     <= node_cnt_d;
      vel_cnt_q      <= vel_cnt_d;
      bad_q          <= bad_d;
    end
  end

  assign shadow_nodes_out = shadow_nodes_q;
  assign shadow_vels_out  = shadow_vels_q;
  assign frame_ok_out     = frame_complete(node_cnt_q, vel_cnt_q, bad_q);
endmodule

// File: rtl/wheel_state_collector.sv
// Collects a streamed wheel frame and commits it atomically into the active node/velocity state.
// Optional WHEEL_COLLECTOR_STATS_EN adds committed/dropped frame counters.
module wheel_state_collector
  import wheel_pkg::*;
(
  input  logic                       clk_in,
  input  logic                       rst_in,
  input  logic                       frame_tick_in,
  input  logic                       init_valid_in,
  input  node_idx_t                  init_idx_in,
  input  pos_t                       init_x_in,
  input  pos_t                       init_y_in,
  input  vel_t                       init_vx_in,
  input  vel_t                       init_vy_in,
  wheel_state_collector_if.slave     up,
  output pos_t [1:0][NUM_NODES-1:0]  nodes_out,
  output vel_t [1:0][NUM_NODES-1:0]  velocities_out,
  output logic                       busy_out,
  output logic                       frame_err_out,
  output state_t                     state_out
`ifdef WHEEL_COLLECTOR_STATS_EN
  ,
  output logic [15:0]                frame_cnt_out,
  output logic [7:0]                 drop_cnt_out
`endif
);
  state_t state_q, state_d;
  logic   begin_q, begin_d;
  logic   err_q, err_d;
  pos_t [1:0][NUM_NODES-1:0] nodes_q, nodes_d;
  vel_t [1:0][NUM_NODES-1:0] vels_q, vels_d;
  pos_t [1:0][NUM_NODES-1:0] shadow_nodes;
  vel_t [1:0][NUM_NODES-1:0] shadow_vels;
  logic clear;
  logic frame_ok;

  wheel_frame_buffer u_buf (
    .clk_in           (clk_in),
    .rst_in           (rst_in),
    .clear_in         (clear),
    .node_we_in       (up.node_in_valid && (state_q == ST_BUSY)),
    .node_x_in        (up.node_in_x),
    .node_y_in        (up.node_in_y),
    .vel_we_in        (up.vel_in_valid && (state_q == ST_BUSY)),
    .vel_x_in         (up.vel_in_x),
    .vel_y_in         (up.vel_in_y),
    .shadow_nodes_out (shadow_nodes),
    .shadow_vels_out  (shadow_vels),
    .frame_ok_out     (frame_ok)
  );

  always_comb begin
    state_d = state_q;
    begin_d = 1'b0;
    err_d   = err_q;
    nodes_d = nodes_q;
    vels_d  = vels_q;
    clear   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (init_valid_in) begin
          nodes_d[0][init_idx_in] = init_x_in;
          nodes_d[1][init_idx_in] = init_y_in;
          vels_d[0][init_idx_in]  = init_vx_in;
          vels_d[1][init_idx_in]  = init_vy_in;
        end
        if (frame_tick_in) begin
          state_d = ST_BUSY;
          begin_d = 1'b1;
          clear   = 1'b1;
        end
      end
      ST_BUSY: begin
        // Strobes in this same cycle are still captured by the buffer before COMMIT judges it.
        if (up.result_in) state_d = ST_COMMIT;
      end
      ST_COMMIT: begin
        if (frame_ok) begin
          nodes_d = shadow_nodes;
          vels_d  = shadow_vels;
        end else begin
          err_d = 1'b1;
        end
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_q <= ST_IDLE;
      begin_q <= 1'b0;
      err_q   <= 1'b0;
      nodes_q <= '0;
      vels_q  <= '0;
    end else begin
      state_q <= state_d;
      begin_q <= begin_d;
      err_q   <= err_d;
      nodes_q <= nodes_d;
      vels_q  <= vels_d;
    end
  end

  assign up.begin_out     = begin_q;
  assign nodes_out        = nodes_q;
  assign velocities_out   = vels_q;
  assign busy_out         = (state_q != ST_IDLE);
  assign frame_err_out    = err_q;
  assign state_out        = state_q;

`ifdef WHEEL_COLLECTOR_STATS_EN
  logic [15:0] frame_cnt_q, frame_cnt_d;
  logic [7:0]  drop_cnt_q, drop_cnt_d;

  // Committed count wraps naturally; dropped count sticks at its maximum.
  always_comb begin
    frame_cnt_d = frame_cnt_q;
    drop_cnt_d  = drop_cnt_q;
    if (state_q == ST_COMMIT) begin
      if (frame_ok) frame_cnt_d = frame_cnt_q + 16'd1;
      else if (drop_cnt_q != 8'hFF) drop_cnt_d = drop_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      frame_cnt_q <= '0;
      drop_cnt_q  <= '0;
    end else begin
      frame_cnt_q <= frame_cnt_d;
      drop_cnt_q  <= drop_cnt_d;
    end
  end

  assign frame_cnt_out = frame_cnt_q;
  assign drop_cnt_out  = drop_cnt_q;
`endif
endmodule

// File: tb/tb_wheel_state_collector.sv
// Directed bench for wheel_state_collector: init writes, good/short/overflow frames, async reset.
module tb_wheel_state_collector;
  import wheel_pkg::*;

  logic      clk_in = 1'b0;
  logic      rst_in = 1'b0;
  logic      frame_tick_in = 1'b0;
  logic      init_valid_in = 1'b0;
  node_idx_t init_idx_in = '0;
  pos_t      init_x_in = '0;
  pos_t      init_y_in = '0;
  vel_t      init_vx_in = '0;
  vel_t      init_vy_in = '0;
  pos_t [1:0][NUM_NODES-1:0] nodes_out;
  vel_t [1:0][NUM_NODES-1:0] velocities_out;
  logic      busy_out;
  logic      frame_err_out;
  state_t    state_out;
`ifdef WHEEL_COLLECTOR_STATS_EN
  logic [15:0] frame_cnt_out;
  logic [7:0]  drop_cnt_out;
`endif

  pos_t [1:0][NUM_NODES-1:0] exp_nodes;
  vel_t [1:0][NUM_NODES-1:0] exp_vels;
  int total = 0;
  int bad = 0;

  wheel_state_collector_if bus ();

  wheel_state_collector dut (
    .clk_in         (clk_in),
    .rst_in         (rst_in),
    .frame_tick_in  (frame_tick_in),
    .init_valid_in  (init_valid_in),
    .init_idx_in    (init_idx_in),
    .init_x_in      (init_x_in),
    .init_y_in      (init_y_in),
    .init_vx_in     (init_vx_in),
    .init_vy_in     (init_vy_in),
    .up             (bus.slave),
    .nodes_out      (nodes_out),
    .velocities_out (velocities_out),
    .busy_out       (busy_out),
    .frame_err_out  (frame_err_out),
    .state_out      (state_out)
`ifdef WHEEL_COLLECTOR_STATS_EN
    ,
    .frame_cnt_out  (frame_cnt_out),
    .drop_cnt_out   (drop_cnt_out)
`endif
  );

  // clock / reset
  always #5 clk_in = ~clk_in;

  task automatic cycle();
    @(posedge clk_in);
    #1;
  endtask

  // driver tasks
  task automatic idle_bus();
    bus.node_in_x = '0;
    bus.node_in_y = '0;
    bus.node_in_valid = 1'b0;
    bus.vel_in_x = '0;
    bus.vel_in_y = '0;
    bus.vel_in_valid = 1'b0;
    bus.result_in = 1'b0;
  endtask

  task automatic drive_strobes(input int k, input int base, input bit nv, input bit vv);
    bus.node_in_x = pos_t'(base + k);
    bus.node_in_y = pos_t'(base + 10 + k);
    bus.node_in_valid = nv;
    bus.vel_in_x = vel_t'(k + 1);
    bus.vel_in_y = vel_t'(-(k + 1));
    bus.vel_in_valid = vv;
  endtask

  task automatic set_exp(input int base);
    for (int i = 0; i < NUM_NODES; i++) begin
      exp_nodes[0][i] = pos_t'(base + i);
      exp_nodes[1][i] = pos_t'(base + 10 + i);
      exp_vels[0][i]  = vel_t'(i + 1);
      exp_vels[1][i]  = vel_t'(-(i + 1));
    end
  endtask

  task automatic wait_idle(input string name);
    for (int i = 0; i < 8 && busy_out; i++) cycle();
    total++;
    if (busy_out !== 1'b0) begin
      bad++;
      $display("FAIL %s_timeout: busy_out=%b required 0", name, busy_out);
    end
  endtask

  // Full frame: n_node/n_vel strobes, result either after or coincident with the last strobe.
  task automatic drive_frame(input int n_node, input int n_vel, input int base, input bit coincide, input string name);
    int n;
    n = (n_node > n_vel) ? n_node : n_vel;
    frame_tick_in = 1'b1;
    cycle();
    frame_tick_in = 1'b0;
    for (int k = 0; k < n; k++) begin
      drive_strobes(k, base, k < n_node, k < n_vel);
      bus.result_in = coincide && (k == n - 1);
      cycle();
    end
    idle_bus();
    if (!coincide) begin
      bus.result_in = 1'b1;
      cycle();
      bus.result_in = 1'b0;
    end
    cycle();
    wait_idle(name);
  endtask

  // scenarios
  task automatic test_reset();
    rst_in = 1'b0;
    idle_bus();
    repeat (2) cycle();
    exp_nodes = '0;
    exp_vels = '0;
    total++; if (nodes_out !== exp_nodes) begin bad++; $display("FAIL reset_nodes: got %h exp %h", nodes_out, exp_nodes); end
    total++; if (velocities_out !== exp_vels) begin bad++; $display("FAIL reset_vels: got %h exp %h", velocities_out, exp_vels); end
    total++; if (busy_out !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b exp 0", busy_out); end
    total++; if (frame_err_out !== 1'b0) begin bad++; $display("FAIL reset_err: got %b exp 0", frame_err_out); end
    total++; if (bus.begin_out !== 1'b0) begin bad++; $display("FAIL reset_begin: got %b exp 0", bus.begin_out); end
    total++; if (state_out !== ST_IDLE) begin bad++; $display("FAIL reset_state: got %0d exp %0d", state_out, ST_IDLE); end
    rst_in = 1'b1;
    cycle();
  endtask

  task automatic test_init();
    int xs[4] = '{3, -2, 2, 3};
    int ys[4] = '{-2, 2, 2, -2};
    for (int i = 0; i < NUM_NODES; i++) begin
      init_valid_in = 1'b1;
      init_idx_in = node_idx_t'(i);
      init_x_in = pos_t'(xs[i]);
      init_y_in = pos_t'(ys[i]);
      init_vx_in = '0;
      init_vy_in = '0;
      exp_nodes[0][i] = pos_t'(xs[i]);
      exp_nodes[1][i] = pos_t'(ys[i]);
      cycle();
    end
    init_valid_in = 1'b0;
    total++; if (nodes_out !== exp_nodes) begin bad++; $display("FAIL init_nodes: got %h exp %h", nodes_out, exp_nodes); end
    total++; if (velocities_out !== exp_vels) begin bad++; $display("FAIL init_vels: got %h exp %h", velocities_out, exp_vels); end
  endtask

  task automatic test_good_frame();
    frame_tick_in = 1'b1;
    cycle();
    frame_tick_in = 1'b0;
    total++; if (bus.begin_out !== 1'b1) begin bad++; $display("FAIL good_begin_pulse: got %b exp 1", bus.begin_out); end
    total++; if (busy_out !== 1'b1) begin bad++; $display("FAIL good_busy: got %b exp 1", busy_out); end
    total++; if (state_out !== ST_BUSY) begin bad++; $display("FAIL good_state_busy: got %0d exp %0d", state_out, ST_BUSY); end
    for (int k = 0; k < NUM_NODES; k++) begin
      drive_strobes(k, 10, 1'b1, 1'b1);
      cycle();
      if (k == 0) begin
        total++; if (bus.begin_out !== 1'b0) begin bad++; $display("FAIL good_begin_one_cycle: got %b exp 0", bus.begin_out); end
      end
      total++; if (nodes_out !== exp_nodes) begin bad++; $display("FAIL good_stable_k%0d: got %h exp %h", k, nodes_out, exp_nodes); end
    end
    idle_bus();
    bus.result_in = 1'b1;
    cycle();
    bus.result_in = 1'b0;
    total++; if (state_out !== ST_COMMIT) begin bad++; $display("FAIL good_state_commit: got %0d exp %0d", state_out, ST_COMMIT); end
    total++; if (nodes_out !== exp_nodes) begin bad++; $display("FAIL good_commit_hold: got %h exp %h", nodes_out, exp_nodes); end
    cycle();
    set_exp(10);
    total++; if (nodes_out !== exp_nodes) begin bad++; $display("FAIL good_nodes: got %h exp %h", nodes_out, exp_nodes); end
    total++; if (velocities_out !== exp_vels) begin bad++; $display("FAIL good_vels: got %h exp %h", velocities_out, exp_vels); end
    total++; if (busy_out !== 1'b0) begin bad++; $display("FAIL good_idle_busy: got %b exp 0", busy_out); end
    total++; if (frame_err_out !== 1'b0) begin bad++; $display("FAIL good_err: got %b exp 0", frame_err_out); end
  endtask

  task automatic test_idle_ignored();
    drive_strobes(0, 99, 1'b1, 1'b1);
    bus.result_in = 1'b1;
    repeat (2) cycle();
    idle_bus();
    total++; if (state_out !== ST_IDLE) begin bad++; $display("FAIL idle_state: got %0d exp %0d", state_out, ST_IDLE); end
    total++; if (bus.begin_out !== 1'b0) begin bad++; $display("FAIL idle_begin: got %b exp 0", bus.begin_out); end
    total++; if (nodes_out !== exp_nodes) begin bad++; $display("FAIL idle_nodes: got %h exp %h", nodes_out, exp_nodes); end
  endtask

  task automatic test_back_to_back();
    int begins = 0;
    frame_tick_in = 1'b1;
    cycle();
    begins += bus.begin_out;
    // tick repeated and init attempted while BUSY must both be ignored
    init_valid_in = 1'b1;
    init_idx_in = '0;
    init_x_in = pos_t'(-100);
    init_y_in = pos_t'(-100);
    cycle();
    begins += bus.begin_out;
    frame_tick_in = 1'b0;
    init_valid_in = 1'b0;
    total++; if (nodes_out !== exp_nodes) begin bad++; $display("FAIL b2b_init_ignored: got %h exp %h", nodes_out, exp_nodes); end
    for (int k = 0; k < NUM_NODES; k++) begin
      drive_strobes(k, 40, 1'b1, 1'b1);
      bus.result_in = (k == NUM_NODES - 1);
      cycle();
      begins += bus.begin_out;
    end
    idle_bus();
    cycle();
    begins += bus.begin_out;
    cycle();
    begins += bus.begin_out;
    set_exp(40);
    total++; if (begins != 1) begin bad++; $display("FAIL b2b_begin_count: got %0d exp 1", begins); end
    total++; if (nodes_out !== exp_nodes) begin bad++; $display("FAIL b2b_nodes: got %h exp %h", nodes_out, exp_nodes); end
    total++; if (frame_err_out !== 1'b0) begin bad++; $display("FAIL b2b_err: got %b exp 0", frame_err_out); end
  endtask

  task automatic test_short_frame();
    drive_frame(3, 4, 70, 1'b0, "short");
    total++; if (nodes_out !== exp_nodes) begin bad++; $display("FAIL short_nodes: got %h exp %h", nodes_out, exp_nodes); end
    total++; if (frame_err_out !== 1'b1) begin bad++; $display("FAIL short_err: got %b exp 1", frame_err_out); end
  endtask

  task automatic test_async_reset();
    frame_tick_in = 1'b1;
    cycle();
    frame_tick_in = 1'b0;
    for (int k = 0; k < 2; k++) begin
      drive_strobes(k, 90, 1'b1, 1'b1);
      cycle();
    end
    idle_bus();
    #2 rst_in = 1'b0;
    #1;
    exp_nodes = '0;
    exp_vels = '0;
    total++; if (nodes_out !== exp_nodes) begin bad++; $display("FAIL arst_nodes: got %h exp %h", nodes_out, exp_nodes); end
    total++; if (velocities_out !== exp_vels) begin bad++; $display("FAIL arst_vels: got %h exp %h", velocities_out, exp_vels); end
    total++; if (busy_out !== 1'b0) begin bad++; $display("FAIL arst_busy: got %b exp 0", busy_out); end
    total++; if (frame_err_out !== 1'b0) begin bad++; $display("FAIL arst_err: got %b exp 0", frame_err_out); end
    total++; if (state_out !== ST_IDLE) begin bad++; $display("FAIL arst_state: got %0d exp %0d", state_out, ST_IDLE); end
    repeat (2) cycle();
    rst_in = 1'b1;
    repeat (3) begin
      cycle();
      total++; if (bus.begin_out !== 1'b0 || state_out !== ST_IDLE) begin
        bad++; $display("FAIL arst_after_release: begin=%b state=%0d exp 0/%0d", bus.begin_out, state_out, ST_IDLE);
      end
    end
  endtask

  task automatic test_overflow();
    drive_frame(4, 4, 10, 1'b0, "ovf_pre");
    set_exp(10);
    total++; if (nodes_out !== exp_nodes) begin bad++; $display("FAIL ovf_pre_nodes: got %h exp %h", nodes_out, exp_nodes); end
    drive_frame(5, 4, 50, 1'b0, "ovf");
    total++; if (nodes_out !== exp_nodes) begin bad++; $display("FAIL ovf_nodes: got %h exp %h", nodes_out, exp_nodes); end
    total++; if (frame_err_out !== 1'b1) begin bad++; $display("FAIL ovf_err: got %b exp 1", frame_err_out); end
    drive_frame(4, 4, 30, 1'b0, "ovf_post");
    set_exp(30);
    total++; if (nodes_out !== exp_nodes) begin bad++; $display("FAIL ovf_post_nodes: got %h exp %h", nodes_out, exp_nodes); end
    total++; if (frame_err_out !== 1'b1) begin bad++; $display("FAIL ovf_err_sticky: got %b exp 1", frame_err_out); end
`ifdef WHEEL_COLLECTOR_STATS_EN
    total++; if (frame_cnt_out !== 16'd2) begin bad++; $display("FAIL stats_frame_cnt: got %0d exp 2", frame_cnt_out); end
    total++; if (drop_cnt_out !== 8'd1) begin bad++; $display("FAIL stats_drop_cnt: got %0d exp 1", drop_cnt_out); end
`endif
  endtask

  initial begin
    test_reset();
    test_init();
    test_good_frame();
    test_idle_ignored();
    test_back_to_back();
    test_short_frame();
    test_async_reset();
    test_overflow();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
